// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Per-layer scheduler (load -> conv -> optional pool -> next) with
//            ping-pong buffer select and a per-phase watchdog.
// Revision : 1.0
// ============================================================================
module layer_sequencer #(
    parameter int                    NUM_LAYERS = 5,
    parameter int                    LIDX_W     = 3,
    parameter logic [NUM_LAYERS-1:0] POOL_MASK  = 5'b10011,
    parameter int                    TIMEOUT    = 65535,
    parameter int                    WD_W       = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              load_done,
    input  logic              end_conv,
    input  logic              pool_done,
    output logic              load_req,
    output logic              start_conv,
    output logic              pool_start,
    output logic [LIDX_W-1:0] layer_idx,
    output logic              buf_sel,
    output logic              busy,
    output logic              net_done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CONV = 3'd2,
        S_POOL = 3'd3,
        S_NEXT = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic              WD_EN    = (TIMEOUT != 0);
    localparam logic [WD_W-1:0]   WD_LAST  = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              end_conv_q, end_conv_d;
    logic              load_req_q, load_req_d;
    logic              start_conv_q, start_conv_d;
    logic              pool_start_q, pool_start_d;
    logic [LIDX_W-1:0] layer_idx_q, layer_idx_d;
    logic              buf_sel_q, buf_sel_d;
    logic              busy_q, busy_d;
    logic              net_done_q, net_done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              conv_edge;
    logic              wd_expired;
    logic              pool_sel;

    always_comb begin
        conv_edge  = end_conv && !end_conv_q;
        wd_expired = WD_EN && (wd_q == WD_LAST);
        end_conv_d = end_conv;

        pool_sel = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_idx_q == LIDX_W'(i)) pool_sel = POOL_MASK[i];
        end

        state_d      = state_q;
        wd_d         = wd_q;
        layer_idx_d  = layer_idx_q;
        buf_sel_d    = buf_sel_q;
        err_code_d   = err_code_q;
        start_conv_d = 1'b0;
        pool_start_d = 1'b0;
        net_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
                    wd_d        = '0;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    state_d      = S_CONV;
                    start_conv_d = 1'b1;
                    wd_d         = '0;
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_CONV: begin
                // A level already high when CONV is entered is not an edge.
                if (conv_edge) begin
                    if (pool_sel) begin
                        state_d      = S_POOL;
                        pool_start_d = 1'b1;
                        wd_d         = '0;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd2;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_POOL: begin
                if (pool_done) begin
                    state_d = S_NEXT;
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                if (layer_idx_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    net_done_d = 1'b1;
                end else begin
                    state_d     = S_LOAD;
                    layer_idx_d = layer_idx_q + LIDX_W'(1);
                    buf_sel_d   = ~buf_sel_q;
                    wd_d        = '0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            wd_d         = '0;
            layer_idx_d  = '0;
            buf_sel_d    = 1'b0;
            err_code_d   = 2'd0;
            start_conv_d = 1'b0;
            pool_start_d = 1'b0;
            net_done_d   = 1'b0;
        end

        // Level outputs follow the next state so they are registered with it.
        load_req_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            end_conv_q   <= 1'b0;
            load_req_q   <= 1'b0;
            start_conv_q <= 1'b0;
            pool_start_q <= 1'b0;
            layer_idx_q  <= '0;
            buf_sel_q    <= 1'b0;
            busy_q       <= 1'b0;
            net_done_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            end_conv_q   <= end_conv_d;
            load_req_q   <= load_req_d;
            start_conv_q <= start_conv_d;
            pool_start_q <= pool_start_d;
            layer_idx_q  <= layer_idx_d;
            buf_sel_q    <= buf_sel_d;
            busy_q       <= busy_d;
            net_done_q   <= net_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign load_req   = load_req_q;
    assign start_conv = start_conv_q;
    assign pool_start = pool_start_q;
    assign layer_idx  = layer_idx_q;
    assign buf_sel    = buf_sel_q;
    assign busy       = busy_q;
    assign net_done   = net_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Purpose  : Directed self-checking bench for layer_sequencer (2 layers,
//            pooling after layer 1, 16-cycle watchdog).
// Revision : 1.0
// ============================================================================
module tb_layer_sequencer;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       start, abort, load_done, end_conv, pool_done;
    logic       load_req, start_conv, pool_start, buf_sel, busy, net_done, err;
    logic [1:0] layer_idx;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;
    int n_sc   = 0;
    int n_ps   = 0;
    int n_nd   = 0;
    int sc_snap;

    layer_sequencer #(
        .NUM_LAYERS (2),
        .LIDX_W     (2),
        .POOL_MASK  (2'b10),
        .TIMEOUT    (16),
        .WD_W       (5)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_done  (load_done),
        .end_conv   (end_conv),
        .pool_done  (pool_done),
        .load_req   (load_req),
        .start_conv (start_conv),
        .pool_start (pool_start),
        .layer_idx  (layer_idx),
        .buf_sel    (buf_sel),
        .busy       (busy),
        .net_done   (net_done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [10:0] outv();
        return {load_req, start_conv, pool_start, layer_idx, buf_sel,
                busy, net_done, err, err_code};
    endfunction

    // Expected output vector: lr sc ps idx bs busy nd err code
    function automatic logic [10:0] ev(logic lr, logic sc, logic ps, logic [1:0] li,
                                       logic bs, logic by, logic nd, logic er,
                                       logic [1:0] ec);
        return {lr, sc, ps, li, bs, by, nd, er, ec};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
        if (start_conv === 1'b1) n_sc++;
        if (pool_start === 1'b1) n_ps++;
        if (net_done === 1'b1) n_nd++;
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        load_done = 1'b0; end_conv = 1'b0; pool_done = 1'b0;
        #12;
        chk("reset_outputs", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));
        @(posedge clk1); #1;
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));

        // Nominal two-layer run, pooling after layer 1
        start = 1'b1; step(); start = 1'b0;
        chk("t1_load0", 32'(outv()), 32'(ev(1,0,0,0,0,1,0,0,0)));
        steps(2);
        chk("t1_load0_hold", 32'(outv()), 32'(ev(1,0,0,0,0,1,0,0,0)));
        load_done = 1'b1; step(); load_done = 1'b0;
        chk("t1_conv0_entry", 32'(outv()), 32'(ev(0,1,0,0,0,1,0,0,0)));
        steps(9);
        chk("t1_conv0_wait", 32'(outv()), 32'(ev(0,0,0,0,0,1,0,0,0)));
        end_conv = 1'b1; step(); end_conv = 1'b0;
        chk("t1_next0", 32'(outv()), 32'(ev(0,0,0,0,0,1,0,0,0)));
        step();
        chk("t1_load1", 32'(outv()), 32'(ev(1,0,0,1,1,1,0,0,0)));
        steps(2);
        load_done = 1'b1; step(); load_done = 1'b0;
        chk("t1_conv1_entry", 32'(outv()), 32'(ev(0,1,0,1,1,1,0,0,0)));
        steps(9);
        end_conv = 1'b1; step(); end_conv = 1'b0;
        chk("t1_pool1_entry", 32'(outv()), 32'(ev(0,0,1,1,1,1,0,0,0)));
        steps(4);
        chk("t1_pool1_wait", 32'(outv()), 32'(ev(0,0,0,1,1,1,0,0,0)));
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("t1_next1", 32'(outv()), 32'(ev(0,0,0,1,1,1,0,0,0)));
        step();
        chk("t1_net_done", 32'(outv()), 32'(ev(0,0,0,1,1,0,1,0,0)));
        step();
        chk("t1_idle", 32'(outv()), 32'(ev(0,0,0,1,1,0,0,0,0)));
        chk("t1_start_conv_pulses", 32'(n_sc), 32'd2);
        chk("t1_pool_start_pulses", 32'(n_ps), 32'd1);
        chk("t1_net_done_pulses", 32'(n_nd), 32'd1);

        // Stale end_conv held high across LOAD->CONV
        start = 1'b1; step(); start = 1'b0;
        chk("t2_restart", 32'(outv()), 32'(ev(1,0,0,0,0,1,0,0,0)));
        end_conv = 1'b1; load_done = 1'b1; step(); load_done = 1'b0;
        chk("t2_conv_entry", 32'(outv()), 32'(ev(0,1,0,0,0,1,0,0,0)));
        steps(3);
        chk("t2_stale_hold", 32'(outv()), 32'(ev(0,0,0,0,0,1,0,0,0)));
        end_conv = 1'b0; step();
        end_conv = 1'b1; step(); end_conv = 1'b0;
        step();
        chk("t2_load1", 32'(outv()), 32'(ev(1,0,0,1,1,1,0,0,0)));

        // end_conv edge on the watchdog's last cycle: event wins
        load_done = 1'b1; step(); load_done = 1'b0;
        chk("t3_conv1_entry", 32'(outv()), 32'(ev(0,1,0,1,1,1,0,0,0)));
        steps(15);
        chk("t3_before_timeout", 32'(outv()), 32'(ev(0,0,0,1,1,1,0,0,0)));
        end_conv = 1'b1; step(); end_conv = 1'b0;
        chk("t3_event_wins", 32'(outv()), 32'(ev(0,0,1,1,1,1,0,0,0)));
        pool_done = 1'b1; step(); pool_done = 1'b0;
        step();
        chk("t3_net_done", 32'(outv()), 32'(ev(0,0,0,1,1,0,1,0,0)));

        // CONV watchdog: end_conv never arrives
        start = 1'b1; step(); start = 1'b0;
        load_done = 1'b1; step(); load_done = 1'b0;
        steps(15);
        chk("t4_pre_timeout", 32'(outv()), 32'(ev(0,0,0,0,0,1,0,0,0)));
        step();
        chk("t4_err_conv", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,1,2)));
        start = 1'b1; steps(2); start = 1'b0;
        chk("t4_start_ignored", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,1,2)));
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4_abort_clears", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));

        // LOAD watchdog
        start = 1'b1; step(); start = 1'b0;
        steps(15);
        chk("t5_pre_timeout", 32'(outv()), 32'(ev(1,0,0,0,0,1,0,0,0)));
        step();
        chk("t5_err_load", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,1,1)));
        abort = 1'b1; step(); abort = 1'b0;
        chk("t5_abort_clears", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));

        // Abort in layer-1 LOAD together with load_done
        start = 1'b1; step(); start = 1'b0;
        load_done = 1'b1; step(); load_done = 1'b0;
        end_conv = 1'b1; step(); end_conv = 1'b0;
        step();
        chk("t6_load1", 32'(outv()), 32'(ev(1,0,0,1,1,1,0,0,0)));
        sc_snap = n_sc;
        abort = 1'b1; load_done = 1'b1; step(); abort = 1'b0; load_done = 1'b0;
        chk("t6_abort", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));
        step();
        chk("t6_no_start_conv", 32'(n_sc), 32'(sc_snap));
        start = 1'b1; step(); start = 1'b0;
        chk("t6_restart", 32'(outv()), 32'(ev(1,0,0,0,0,1,0,0,0)));

        // Asynchronous reset mid-layer
        load_done = 1'b1; step(); load_done = 1'b0;
        #2; rst_n = 1'b0; #1;
        chk("t7_async_reset", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));
        steps(2);
        chk("t7_reset_held", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));
        rst_n = 1'b1;
        step();
        chk("t7_idle_after", 32'(outv()), 32'(ev(0,0,0,0,0,0,0,0,0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
